// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the dcache/icache memory-port arbiter.
// Optional statistics counters are enabled with the ARB_STATS_EN macro (see mem_bus_arbiter).
package mem_bus_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int NUM_MEM_TAGS = 16;
  localparam int TAG_W        = $clog2(NUM_MEM_TAGS);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } ARB_OWNER;

  typedef struct packed {
    logic     valid;
    ARB_OWNER owner;
  } MEM_TAG_OWNER_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of cache-side, memory-side and status signals around the arbiter.
// slave = arbiter view, master = surrounding caches/memory view.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic [1:0]      proc2Dmem_command;
  logic [XLEN-1:0] proc2Dmem_addr;
  logic [63:0]     proc2Dmem_data;
  logic [1:0]      proc2Imem_command;
  logic [XLEN-1:0] proc2Imem_addr;

  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;

  logic [TAG_W-1:0] Dmem2proc_response;
  logic [TAG_W-1:0] Imem2proc_response;
  logic [63:0]      Dmem2proc_data;
  logic [63:0]      Imem2proc_data;
  logic [TAG_W-1:0] Dmem2proc_tag;
  logic [TAG_W-1:0] Imem2proc_tag;

  logic             grant_dcache;
  logic             starve_force;
  logic [3:0]       icache_outstanding;

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  proc2Imem_command, proc2Imem_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output Dmem2proc_response, Imem2proc_response,
    output Dmem2proc_data, Imem2proc_data,
    output Dmem2proc_tag, Imem2proc_tag,
    output grant_dcache, starve_force, icache_outstanding
  );

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output proc2Imem_command, proc2Imem_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  Dmem2proc_response, Imem2proc_response,
    input  Dmem2proc_data, Imem2proc_data,
    input  Dmem2proc_tag, Imem2proc_tag,
    input  grant_dcache, starve_force, icache_outstanding
  );

endinterface

// File: rtl/mem_bus_arbiter_owner_table.sv
// Records which cache issued each outstanding memory load tag.
// A free and an allocate of the same tag in one cycle leaves the entry allocated.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [TAG_W-1:0]   lookup_tag,
  input  logic               free_en,
  input  logic               alloc_en,
  input  logic [TAG_W-1:0]   alloc_tag,
  input  ARB_OWNER           alloc_owner,
  output MEM_TAG_OWNER_ENTRY lookup_entry
);

  logic [NUM_MEM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_MEM_TAGS-1:0] owner_q, owner_d;

  generate
    for (genvar gi = 0; gi < NUM_MEM_TAGS; gi++) begin : g_entry
      logic hit_alloc;
      logic hit_free;
      assign hit_alloc    = alloc_en && (alloc_tag == TAG_W'(gi));
      assign hit_free     = free_en && (lookup_tag == TAG_W'(gi));
      assign valid_d[gi]  = hit_alloc | (valid_q[gi] & ~hit_free);
      assign owner_d[gi]  = hit_alloc ? alloc_owner : owner_q[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign lookup_entry.valid = valid_q[lookup_tag];
  assign lookup_entry.owner = ARB_OWNER'(owner_q[lookup_tag]);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory port between dcache (fixed priority) and icache (starvation-forced),
// and routes returning tags to the issuing cache. ARB_STATS_EN adds grant/conflict counters.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset_n,
  mem_bus_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] stat_dc_grants,
  output logic [31:0] stat_ic_grants,
  output logic [31:0] stat_conflicts
`endif
);

  logic [3:0]         starve_q, starve_d;
  logic [3:0]         ic_out_q, ic_out_d;
  logic               dc_req, ic_req, force_ic;
  logic               grant_d, grant_i, resp_nz;
  logic               alloc_en, route_ic, ic_accept;
  logic [TAG_W-1:0]   ret_tag;
  MEM_TAG_OWNER_ENTRY ret_entry;

  // Requests are masked during reset so every output collapses to zero immediately.
  assign dc_req   = reset_n && (bus.proc2Dmem_command == BUS_LOAD ||
                                bus.proc2Dmem_command == BUS_STORE);
  assign ic_req   = reset_n && (bus.proc2Imem_command == BUS_LOAD);
  assign force_ic = ic_req && (starve_q == 4'(STARVE_MAX));
  assign grant_d  = dc_req && !force_ic;
  assign grant_i  = ic_req && !grant_d;
  assign resp_nz  = (bus.mem2proc_response != '0);

  assign bus.proc2mem_command = grant_d ? bus.proc2Dmem_command :
                                grant_i ? 2'(BUS_LOAD) : 2'(BUS_NONE);
  assign bus.proc2mem_addr    = grant_d ? bus.proc2Dmem_addr :
                                grant_i ? bus.proc2Imem_addr : '0;
  assign bus.proc2mem_data    = grant_d ? bus.proc2Dmem_data : '0;

  assign bus.Dmem2proc_response = grant_d ? bus.mem2proc_response : '0;
  assign bus.Imem2proc_response = grant_i ? bus.mem2proc_response : '0;
  assign bus.grant_dcache       = grant_d;
  assign bus.starve_force       = force_ic;
  assign bus.icache_outstanding = ic_out_q;

  assign ic_accept = grant_i && resp_nz;
  assign alloc_en  = resp_nz && ((grant_d && bus.proc2Dmem_command == BUS_LOAD) || grant_i);

  assign ret_tag  = reset_n ? bus.mem2proc_tag : '0;
  assign route_ic = (ret_tag != '0) && ret_entry.valid && (ret_entry.owner == OWNER_ICACHE);

  // Tags nobody claims (stores, stale tags) default to the dcache side.
  assign bus.Dmem2proc_tag  = ((ret_tag != '0) && !route_ic) ? ret_tag : '0;
  assign bus.Imem2proc_tag  = route_ic ? ret_tag : '0;
  assign bus.Dmem2proc_data = reset_n ? bus.mem2proc_data : '0;
  assign bus.Imem2proc_data = reset_n ? bus.mem2proc_data : '0;

  mem_tag_owner_table u_owner_table (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_tag   (ret_tag),
    .free_en      ((ret_tag != '0) && ret_entry.valid),
    .alloc_en     (alloc_en),
    .alloc_tag    (bus.mem2proc_response),
    .alloc_owner  (grant_d ? OWNER_DCACHE : OWNER_ICACHE),
    .lookup_entry (ret_entry)
  );

  always_comb begin
    starve_d = starve_q;
    if (!ic_req) begin
      starve_d = '0;
    end else if (grant_i) begin
      if (resp_nz) starve_d = '0;
    end else if (starve_q < 4'(STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    ic_out_d = ic_out_q;
    if (ic_accept && !route_ic && ic_out_q != 4'd15) begin
      ic_out_d = ic_out_q + 4'd1;
    end else if (route_ic && !ic_accept && ic_out_q != 4'd0) begin
      ic_out_d = ic_out_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      ic_out_q <= '0;
    end else begin
      starve_q <= starve_d;
      ic_out_q <= ic_out_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] dc_grants_q, ic_grants_q, conflicts_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dc_grants_q <= '0;
      ic_grants_q <= '0;
      conflicts_q <= '0;
    end else begin
      if (grant_d && resp_nz) dc_grants_q <= dc_grants_q + 32'd1;
      if (ic_accept)          ic_grants_q <= ic_grants_q + 32'd1;
      if (dc_req && ic_req)   conflicts_q <= conflicts_q + 32'd1;
    end
  end

  assign stat_dc_grants = dc_grants_q;
  assign stat_ic_grants = ic_grants_q;
  assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// corner sequences (tag reuse, unowned store tag, async reset) and a randomized model phase.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();

`ifdef ARB_STATS_EN
  logic [31:0] s_dc, s_ic, s_cf;
`endif

  mem_bus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_dc_grants (s_dc),
    .stat_ic_grants (s_ic),
    .stat_conflicts (s_cf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [31:0] ia, input logic [3:0] resp,
                       input logic [3:0] rtag, input logic [63:0] rdata);
    bus.proc2Dmem_command = dc;
    bus.proc2Dmem_addr    = da;
    bus.proc2Dmem_data    = dd;
    bus.proc2Imem_command = ic;
    bus.proc2Imem_addr    = ia;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = rtag;
    bus.mem2proc_data     = rdata;
  endtask

  typedef struct {
    logic [1:0]  dc;   logic [31:0] da; logic [63:0] dd;
    logic [1:0]  ic;   logic [31:0] ia;
    logic [3:0]  resp; logic [3:0] rtag; logic [63:0] rdata;
    logic [1:0]  e_cmd; logic [31:0] e_addr; logic [63:0] e_data;
    logic        e_gd; logic e_force;
    logic [3:0]  e_dresp, e_iresp, e_dtag, e_itag, e_iout;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  // Behavioural model state: tag -> owner (1 = dcache) for outstanding loads.
  int starve;
  int ic_out;
  int owner_of [int];

  initial begin
    // dc, da, dd, ic, ia, resp, rtag, rdata | cmd, addr, data, gd, force, dresp, iresp, dtag, itag, iout
    vecs[0]  = '{1, 'h100, 0, 1, 'h200, 1, 0, 0,        1, 'h100, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 'h100, 0, 1, 'h200, 1, 0, 0,        1, 'h100, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[2]  = '{1, 'h100, 0, 1, 'h200, 1, 0, 0,        1, 'h100, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 'h100, 0, 1, 'h200, 1, 0, 0,        1, 'h100, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 'h100, 0, 1, 'h200, 5, 0, 0,        1, 'h200, 0, 0, 1, 0, 5, 0, 0, 0};
    vecs[5]  = '{1, 'h100, 0, 1, 'h200, 0, 0, 0,        1, 'h100, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 5, 'hDEAD,           0, 0, 0, 0, 0, 0, 0, 0, 5, 1};
    vecs[7]  = '{1, 'h300, 0, 0, 0, 0, 0, 0,            1, 'h300, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 'h300, 0, 0, 0, 2, 0, 0,            1, 'h300, 0, 1, 0, 2, 0, 0, 0, 0};
    vecs[9]  = '{2, 'h400, 'hCAFE, 0, 0, 0, 2, 'hBEEF,  2, 'h400, 'hCAFE, 1, 0, 0, 0, 2, 0, 0};
    vecs[10] = '{0, 0, 0, 2, 'h500, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset held with active inputs: every output must be zero.
    drive(1, 'h100, 'h11, 1, 'h200, 3, 4, 'h1234);
    #1;
    chk("rst cmd",   bus.proc2mem_command, 0);
    chk("rst addr",  bus.proc2mem_addr, 0);
    chk("rst gd",    bus.grant_dcache, 0);
    chk("rst dresp", bus.Dmem2proc_response, 0);
    chk("rst dtag",  bus.Dmem2proc_tag, 0);
    chk("rst ddata", bus.Dmem2proc_data, 0);
    chk("rst iout",  bus.icache_outstanding, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].dc, vecs[i].da, vecs[i].dd, vecs[i].ic, vecs[i].ia,
            vecs[i].resp, vecs[i].rtag, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d cmd", i),   bus.proc2mem_command,   vecs[i].e_cmd);
      chk($sformatf("v%0d addr", i),  bus.proc2mem_addr,      vecs[i].e_addr);
      chk($sformatf("v%0d data", i),  bus.proc2mem_data,      vecs[i].e_data);
      chk($sformatf("v%0d gd", i),    bus.grant_dcache,       vecs[i].e_gd);
      chk($sformatf("v%0d force", i), bus.starve_force,       vecs[i].e_force);
      chk($sformatf("v%0d dresp", i), bus.Dmem2proc_response, vecs[i].e_dresp);
      chk($sformatf("v%0d iresp", i), bus.Imem2proc_response, vecs[i].e_iresp);
      chk($sformatf("v%0d dtag", i),  bus.Dmem2proc_tag,      vecs[i].e_dtag);
      chk($sformatf("v%0d itag", i),  bus.Imem2proc_tag,      vecs[i].e_itag);
      chk($sformatf("v%0d iout", i),  bus.icache_outstanding, vecs[i].e_iout);
      chk($sformatf("v%0d ddata", i), bus.Dmem2proc_data,     vecs[i].rdata);
      chk($sformatf("v%0d idata", i), bus.Imem2proc_data,     vecs[i].rdata);
      $display("vec %0d: cmd=%0d addr=%0h gd=%0b force=%0b dtag=%0d itag=%0d iout=%0d", i,
               bus.proc2mem_command, bus.proc2mem_addr, bus.grant_dcache, bus.starve_force,
               bus.Dmem2proc_tag, bus.Imem2proc_tag, bus.icache_outstanding);
      @(posedge clk); #1;
    end

    // Tag reuse: icache owns tag 7, then it returns while dcache is accepted with tag 7.
    drive(0, 0, 0, 1, 'h700, 7, 0, 0);
    @(negedge clk);
    chk("reuse iresp", bus.Imem2proc_response, 7);
    @(posedge clk); #1;
    drive(1, 'h710, 0, 0, 0, 7, 7, 'h77);
    @(negedge clk);
    chk("reuse itag",  bus.Imem2proc_tag, 7);
    chk("reuse dtag",  bus.Dmem2proc_tag, 0);
    chk("reuse dresp", bus.Dmem2proc_response, 7);
    chk("reuse iout",  bus.icache_outstanding, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 7, 'h78);
    @(negedge clk);
    chk("reuse2 dtag", bus.Dmem2proc_tag, 7);
    chk("reuse2 itag", bus.Imem2proc_tag, 0);
    chk("reuse2 iout", bus.icache_outstanding, 0);
    $display("seq tag-reuse done");
    @(posedge clk); #1;

    // Unowned store tag: icache has one load outstanding that must not be disturbed.
    drive(0, 0, 0, 1, 'h900, 9, 0, 0);
    @(posedge clk); #1;
    drive(2, 'h330, 'h55, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("store dresp", bus.Dmem2proc_response, 3);
    chk("store iout",  bus.icache_outstanding, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 3, 'h33);
    @(negedge clk);
    chk("store dtag", bus.Dmem2proc_tag, 3);
    chk("store itag", bus.Imem2proc_tag, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("store iout2", bus.icache_outstanding, 1);
    $display("seq unowned-store done");
    @(posedge clk); #1;

    // Async reset with three icache loads in flight.
    drive(0, 0, 0, 1, 'hA00, 10, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 'hB00, 11, 0, 0);
    @(posedge clk); #1;
    drive(1, 'h100, 'h5, 1, 'h200, 4, 9, 'h99);
    @(negedge clk);
    chk("pre-rst iout", bus.icache_outstanding, 3);
    chk("pre-rst itag", bus.Imem2proc_tag, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst cmd",   bus.proc2mem_command, 0);
    chk("arst gd",    bus.grant_dcache, 0);
    chk("arst iresp", bus.Imem2proc_response, 0);
    chk("arst itag",  bus.Imem2proc_tag, 0);
    chk("arst idata", bus.Imem2proc_data, 0);
    chk("arst iout",  bus.icache_outstanding, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 10, 'h10);
    @(negedge clk);
    chk("post-rst dtag", bus.Dmem2proc_tag, 10);
    chk("post-rst itag", bus.Imem2proc_tag, 0);
    chk("post-rst iout", bus.icache_outstanding, 0);
    $display("seq async-reset done");
    @(posedge clk); #1;

    // Randomized phase against the behavioural model.
    starve = 0;
    ic_out = 0;
    owner_of.delete();
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  dc, ic, e_cmd;
      logic [31:0] da, ia, e_addr;
      logic [63:0] dd, rd;
      logic [3:0]  resp, rtag, e_dtag, e_itag;
      bit          dreq, ireq, frc, gd, gi, to_ic;
      int          r;
      r    = $urandom_range(0, 3);
      dc   = (r == 3) ? 2'd1 : 2'(r);
      r    = $urandom_range(0, 3);
      ic   = (r < 2) ? 2'd1 : ((r == 2) ? 2'd0 : 2'd2);
      da   = $urandom;
      ia   = $urandom;
      dd   = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      resp = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      rtag = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'd0;

      dreq  = (dc == 2'd1) || (dc == 2'd2);
      ireq  = (ic == 2'd1);
      frc   = ireq && (starve == STARVE_MAX);
      gd    = dreq && !frc;
      gi    = ireq && !gd;
      e_cmd  = gd ? dc : (gi ? 2'd1 : 2'd0);
      e_addr = gd ? da : (gi ? ia : 32'd0);
      to_ic  = (rtag != 0) && owner_of.exists(int'(rtag)) && (owner_of[int'(rtag)] == 0);
      e_dtag = ((rtag != 0) && !to_ic) ? rtag : 4'd0;
      e_itag = to_ic ? rtag : 4'd0;

      drive(dc, da, dd, ic, ia, resp, rtag, rd);
      @(negedge clk);
      chk($sformatf("r%0d cmd", n),   bus.proc2mem_command, e_cmd);
      chk($sformatf("r%0d addr", n),  bus.proc2mem_addr, e_addr);
      chk($sformatf("r%0d data", n),  bus.proc2mem_data, gd ? dd : 64'd0);
      chk($sformatf("r%0d gd", n),    bus.grant_dcache, gd);
      chk($sformatf("r%0d force", n), bus.starve_force, frc);
      chk($sformatf("r%0d dresp", n), bus.Dmem2proc_response, gd ? resp : 4'd0);
      chk($sformatf("r%0d iresp", n), bus.Imem2proc_response, gi ? resp : 4'd0);
      chk($sformatf("r%0d dtag", n),  bus.Dmem2proc_tag, e_dtag);
      chk($sformatf("r%0d itag", n),  bus.Imem2proc_tag, e_itag);
      chk($sformatf("r%0d iout", n),  bus.icache_outstanding, 4'(ic_out));
      $display("rnd %0d: dc=%0d ic=%0d resp=%0d rtag=%0d gd=%0b force=%0b iout=%0d",
               n, dc, ic, resp, rtag, gd, frc, ic_out);

      if ((rtag != 0) && owner_of.exists(int'(rtag))) owner_of.delete(int'(rtag));
      if (resp != 0 && ((gd && dc == 2'd1) || gi)) owner_of[int'(resp)] = gd ? 1 : 0;
      if (!ireq)     starve = 0;
      else if (gi)   starve = (resp != 0) ? 0 : starve;
      else           starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
      ic_out = ic_out + ((gi && resp != 0) ? 1 : 0) - (to_ic ? 1 : 0);
      if (ic_out > 15) ic_out = 15;
      if (ic_out < 0)  ic_out = 0;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
